mem_stage_lsu: RTL and testbench



---
 rtl/mem_stage_lsu_pkg.sv | 25 ++
 rtl/mem_stage_lsu_if.sv | 28 ++
 rtl/mem_stage_lsu_load_format.sv | 29 ++
 rtl/mem_stage_lsu.sv | 166 ++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
// Holds the funct3 encodings of the RV32I loads and stores, the LSU state
// type and the unshifted byte-enable patterns for each access size.
package riscv_mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory request/ready bus between the LSU and data memory.
//   dmem_req    request valid, held until dmem_ready
//   dmem_we     1 = write
//   dmem_addr   word-aligned byte address
//   dmem_wdata  lane-replicated store data
//   dmem_be     byte enables
//   dmem_ready  memory completes the request this cycle
//   dmem_rdata  read word, valid with dmem_ready
// master = LSU side, slave = memory side.
interface mem_stage_lsu_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/mem_stage_lsu_load_format.sv
// Load data formatter: selects the addressed byte/half of a read word and
// sign- or zero-extends it according to funct3.
//   rdata   in  32  raw word from memory
//   funct3  in  3   load size/sign
//   offset  in  2   byte offset within the word
//   result  out 32  formatted load value
module lsu_load_format
    import riscv_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    output logic [31:0] result
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  result = {24'h0, byte_sel};
            F3_LH:   result = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  result = {16'h0, half_sel};
            default: result = rdata;
        endcase
    end
endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit. Issues one data-memory request per load/store,
// stalls the pipeline until it completes, formats load data into a register
// for MEM/WB and flags misaligned/illegal accesses and memory timeouts.
//   clk, rst              clock, synchronous active-high reset
//   MemRead_mem/MemWrite_mem, funct3_mem, ALUResult_mem, StoreData_mem
//                         access description from EX/MEM
//   dmem                  data-memory bus (master side)
//   MemDout_mem           registered load result
//   stall_mem             freeze the front of the pipeline
//   mem_exc               one-cycle exception pulse
//
// state | meaning
// IDLE  | no access outstanding; a good access is latched and stalls here
// BUSY  | request on the bus, waiting for dmem_ready or timeout
// DONE  | access finished; pipeline released, MEM/WB captures MemDout_mem
module mem_stage_lsu
    import riscv_mem_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int WAIT_W   = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            MemRead_mem,
    input  logic            MemWrite_mem,
    input  logic [2:0]      funct3_mem,
    input  logic [31:0]     ALUResult_mem,
    input  logic [31:0]     StoreData_mem,
    mem_stage_lsu_if.master dmem,
    output logic [31:0]     MemDout_mem,
    output logic            stall_mem,
    output logic            mem_exc
);
    lsu_state_t  state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic        timeout_q;
    logic        we_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  be_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;

    logic        access, bad, accept, wait_last, req_c;
    logic [1:0]  off;
    logic [3:0]  be_c;
    logic [31:0] wdata_c, load_val;

    assign off    = ALUResult_mem[1:0];
    assign access = MemRead_mem | MemWrite_mem;
    assign bad    = (MemRead_mem & MemWrite_mem)
                  | (funct3_mem == 3'b011) | (funct3_mem[2:1] == 2'b11)
                  | ((funct3_mem[1:0] == 2'b01) & off[0])
                  | ((funct3_mem[1:0] == 2'b10) & (off != 2'b00));
    assign accept    = (state == IDLE) & access & ~bad;
    assign wait_last = (wait_cnt == WAIT_W'(MAX_WAIT - 1));

    // Stores size by funct3[1:0]; loads always read the whole word.
    always_comb begin
        be_c    = BE_WORD;
        wdata_c = 32'h0;
        if (MemWrite_mem) begin
            case (funct3_mem[1:0])
                2'b00: begin
                    be_c    = BE_BYTE << off;
                    wdata_c = {4{StoreData_mem[7:0]}};
                end
                2'b01: begin
                    be_c    = BE_HALF << off;
                    wdata_c = {2{StoreData_mem[15:0]}};
                end
                default: begin
                    be_c    = BE_WORD;
                    wdata_c = StoreData_mem;
                end
            endcase
        end
    end

    lsu_load_format u_fmt (
        .rdata  (dmem.dmem_rdata),
        .funct3 (f3_q),
        .offset (off_q),
        .result (load_val)
    );

    always_comb begin
        state_nxt = state;
        stall_mem = 1'b0;
        mem_exc   = 1'b0;
        req_c     = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    if (bad) begin
                        mem_exc = 1'b1;
                    end else begin
                        stall_mem = 1'b1;
                        state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                req_c     = 1'b1;
                stall_mem = 1'b1;
                if (dmem.dmem_ready || wait_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                mem_exc   = timeout_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            timeout_q   <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            be_q        <= 4'h0;
            f3_q        <= 3'h0;
            off_q       <= 2'h0;
            MemDout_mem <= 32'h0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    wait_cnt  <= '0;
                    timeout_q <= 1'b0;
                    if (accept) begin
                        we_q    <= MemWrite_mem;
                        addr_q  <= {ALUResult_mem[31:2], 2'b00};
                        wdata_q <= wdata_c;
                        be_q    <= be_c;
                        f3_q    <= funct3_mem;
                        off_q   <= off;
                    end
                end
                BUSY: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    // Ready on the last permitted cycle still completes normally.
                    if (dmem.dmem_ready) begin
                        if (!we_q) begin
                            MemDout_mem <= load_val;
                        end
                    end else if (wait_last) begin
                        MemDout_mem <= 32'h0;
                        timeout_q   <= 1'b1;
                    end
                end
                default: timeout_q <= 1'b0;
            endcase
        end
    end

    assign dmem.dmem_req   = req_c;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign dmem.dmem_be    = be_q;
endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;
    import riscv_mem_pkg::*;

    localparam int MAX_WAIT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead_mem, MemWrite_mem;
    logic [2:0]  funct3_mem;
    logic [31:0] ALUResult_mem, StoreData_mem;
    logic [31:0] MemDout_mem;
    logic        stall_mem, mem_exc;

    int tests_run = 0;
    int tests_failed = 0;

    mem_stage_lsu_if dmem_bus ();

    mem_stage_lsu #(.MAX_WAIT(MAX_WAIT), .WAIT_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .MemRead_mem   (MemRead_mem),
        .MemWrite_mem  (MemWrite_mem),
        .funct3_mem    (funct3_mem),
        .ALUResult_mem (ALUResult_mem),
        .StoreData_mem (StoreData_mem),
        .dmem          (dmem_bus),
        .MemDout_mem   (MemDout_mem),
        .stall_mem     (stall_mem),
        .mem_exc       (mem_exc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sdata);
        MemRead_mem   = rd;
        MemWrite_mem  = wr;
        funct3_mem    = f3;
        ALUResult_mem = addr;
        StoreData_mem = sdata;
    endtask

    // Full good access. ready_at = BUSY cycle (1-based) on which memory
    // answers; 0 = never answers.
    task automatic run_access(input string tag, input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] sdata, input logic [31:0] rdata,
                              input int ready_at, input logic [3:0] exp_be,
                              input logic [31:0] exp_wdata, input logic [31:0] exp_dout,
                              input logic exp_exc, input int exp_busy);
        int busy_n = 0;
        int stall_n = 0;
        set_in(rd, wr, f3, addr, sdata);
        dmem_bus.dmem_ready = 1'b0;
        dmem_bus.dmem_rdata = 32'h0;
        #1;
        chk({tag, " detect stall"}, 32'(stall_mem), 32'd1);
        chk({tag, " detect req"}, 32'(dmem_bus.dmem_req), 32'd0);
        if (stall_mem) stall_n++;
        next_cycle();
        for (int n = 1; n <= MAX_WAIT + 2; n++) begin
            if (n == 1) begin
                chk({tag, " addr"}, dmem_bus.dmem_addr, {addr[31:2], 2'b00});
                chk({tag, " be"}, 32'(dmem_bus.dmem_be), 32'(exp_be));
                chk({tag, " wdata"}, dmem_bus.dmem_wdata, exp_wdata);
                chk({tag, " we"}, 32'(dmem_bus.dmem_we), 32'(wr));
            end
            if (!dmem_bus.dmem_req) break;
            if (stall_mem) stall_n++;
            busy_n++;
            dmem_bus.dmem_ready = (n == ready_at);
            dmem_bus.dmem_rdata = (n == ready_at) ? rdata : 32'h0;
            next_cycle();
            dmem_bus.dmem_ready = 1'b0;
            dmem_bus.dmem_rdata = 32'h0;
        end
        chk({tag, " busy cycles"}, 32'(busy_n), 32'(exp_busy));
        if (exp_busy == 1)
            chk({tag, " stall cycles"}, 32'(stall_n), 32'd2);
        chk({tag, " done stall"}, 32'(stall_mem), 32'd0);
        chk({tag, " done req"}, 32'(dmem_bus.dmem_req), 32'd0);
        chk({tag, " done exc"}, 32'(mem_exc), 32'(exp_exc));
        chk({tag, " dout"}, MemDout_mem, exp_dout);
        next_cycle();
        chk({tag, " no reissue"}, 32'(dmem_bus.dmem_req), 32'd0);
        set_in(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        chk({tag, " idle stall"}, 32'(stall_mem), 32'd0);
        chk({tag, " idle exc"}, 32'(mem_exc), 32'd0);
    endtask

    task automatic run_bad(input string tag, input logic rd, input logic wr,
                           input logic [2:0] f3, input logic [31:0] addr);
        set_in(rd, wr, f3, addr, 32'h5555_5555);
        #1;
        chk({tag, " exc"}, 32'(mem_exc), 32'd1);
        chk({tag, " stall"}, 32'(stall_mem), 32'd0);
        next_cycle();
        chk({tag, " req"}, 32'(dmem_bus.dmem_req), 32'd0);
        set_in(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        chk({tag, " exc clears"}, 32'(mem_exc), 32'd0);
        next_cycle();
    endtask

    initial begin
        rst = 1'b1;
        set_in(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        dmem_bus.dmem_ready = 1'b0;
        dmem_bus.dmem_rdata = 32'h0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        #1;
        chk("rst stall", 32'(stall_mem), 32'd0);
        chk("rst req", 32'(dmem_bus.dmem_req), 32'd0);
        chk("rst exc", 32'(mem_exc), 32'd0);
        chk("rst dout", MemDout_mem, 32'h0);
        chk("rst addr", dmem_bus.dmem_addr, 32'h0);
        chk("rst be", 32'(dmem_bus.dmem_be), 32'h0);
        chk("rst we", 32'(dmem_bus.dmem_we), 32'h0);
        next_cycle();

        //          tag     rd    wr    f3      addr          sdata         rdata         rdy be       wdata         dout          exc   busy
        run_access("LW",   1'b1, 1'b0, F3_LW,  32'h100, 32'h0, 32'hDEADBEEF, 1, 4'b1111, 32'h0, 32'hDEADBEEF, 1'b0, 1);
        run_access("LB",   1'b1, 1'b0, F3_LB,  32'h103, 32'h0, 32'h80123456, 1, 4'b1111, 32'h0, 32'hFFFFFF80, 1'b0, 1);
        run_access("LBU",  1'b1, 1'b0, F3_LBU, 32'h103, 32'h0, 32'h80123456, 1, 4'b1111, 32'h0, 32'h00000080, 1'b0, 1);
        run_access("LHU",  1'b1, 1'b0, F3_LHU, 32'h102, 32'h0, 32'h80123456, 1, 4'b1111, 32'h0, 32'h00008012, 1'b0, 1);
        run_access("LH",   1'b1, 1'b0, F3_LH,  32'h102, 32'h0, 32'h80123456, 2, 4'b1111, 32'h0, 32'hFFFF8012, 1'b0, 2);
        run_access("LB0",  1'b1, 1'b0, F3_LB,  32'h100, 32'h0, 32'h80123456, 1, 4'b1111, 32'h0, 32'h00000056, 1'b0, 1);
        run_access("SB",   1'b0, 1'b1, F3_SB,  32'h201, 32'h000000AB, 32'hFFFFFFFF, 1, 4'b0010, 32'hABABABAB, 32'h00000056, 1'b0, 1);
        run_access("SH",   1'b0, 1'b1, F3_SH,  32'h202, 32'h00001234, 32'hFFFFFFFF, 1, 4'b1100, 32'h12341234, 32'h00000056, 1'b0, 1);
        run_access("SW",   1'b0, 1'b1, F3_SW,  32'h204, 32'hCAFEF00D, 32'hFFFFFFFF, 3, 4'b1111, 32'hCAFEF00D, 32'h00000056, 1'b0, 3);

        run_bad("LW mis",   1'b1, 1'b0, F3_LW,  32'h101);
        run_bad("f3 011",   1'b1, 1'b0, 3'b011, 32'h100);
        run_bad("rd+wr",    1'b1, 1'b1, F3_LW,  32'h100);
        run_bad("SH mis",   1'b0, 1'b1, F3_SH,  32'h203);
        run_bad("f3 110",   1'b1, 1'b0, 3'b110, 32'h100);

        // Stray ready while idle must not touch the load register.
        dmem_bus.dmem_ready = 1'b1;
        dmem_bus.dmem_rdata = 32'h12345678;
        next_cycle();
        dmem_bus.dmem_ready = 1'b0;
        chk("idle ready dout", MemDout_mem, 32'h00000056);
        chk("idle ready stall", 32'(stall_mem), 32'd0);

        run_access("timeout", 1'b1, 1'b0, F3_LW, 32'h300, 32'h0, 32'h0,
                   0, 4'b1111, 32'h0, 32'h0, 1'b1, MAX_WAIT);
        run_access("rdy16", 1'b1, 1'b0, F3_LW, 32'h304, 32'h0, 32'h11223344,
                   MAX_WAIT, 4'b1111, 32'h0, 32'h11223344, 1'b0, MAX_WAIT);

        // Reset during the third BUSY cycle.
        set_in(1'b1, 1'b0, F3_LW, 32'h100, 32'h0);
        next_cycle();
        next_cycle();
        next_cycle();
        chk("rst busy req", 32'(dmem_bus.dmem_req), 32'd1);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        set_in(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        chk("rst busy req drop", 32'(dmem_bus.dmem_req), 32'd0);
        chk("rst busy stall", 32'(stall_mem), 32'd0);
        chk("rst busy dout", MemDout_mem, 32'h0);
        next_cycle();
        run_access("LW after rst", 1'b1, 1'b0, F3_LW, 32'h100, 32'h0, 32'hDEADBEEF,
                   1, 4'b1111, 32'h0, 32'hDEADBEEF, 1'b0, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
